// File: rtl/clock_pkg.sv
// Shared definitions for the digital-clock BCD counters: timer states, BCD digit
// limits and preset validity checks.
package clock_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSE   = 2'd2,
        EXPIRED = 2'd3
    } state_e;

    localparam logic [3:0] UNIT_MAX = 4'h9;
    localparam logic [3:0] TENS_MAX = 4'h5;

    // One mod-60 BCD field: tens digit 0..5, units digit 0..9.
    function automatic logic bcd60_ok(input logic [7:0] v);
        return (v[3:0] <= UNIT_MAX) && (v[7:4] <= TENS_MAX);
    endfunction

    function automatic logic preset_ok(input logic [15:0] p);
        return bcd60_ok(p[15:8]) && bcd60_ok(p[7:0]);
    endfunction

endpackage

// File: rtl/countdown60x60_if.sv
// Control/data bundle of the MM:SS countdown timer; the timer takes the slave
// side, whoever drives the commands takes the master side.
interface countdown60x60_if;

    logic        EN;
    logic        Load;
    logic [15:0] Preset;
    logic        Start;
    logic        Stop;
    logic [15:0] Cnt;
    logic        Busy;
    logic        Done;
    logic        Expired;
    logic        LoadErr;

    modport master (
        output EN, Load, Preset, Start, Stop,
        input  Cnt, Busy, Done, Expired, LoadErr
    );

    modport slave (
        input  EN, Load, Preset, Start, Stop,
        output Cnt, Busy, Done, Expired, LoadErr
    );

endinterface

// File: rtl/countdown60x60_down60.sv
// 8-bit BCD mod-60 down counter (59 -> 00, wraps to 59) with enable,
// synchronous load and a borrow-out raised when enabled at 00.
module down60
    import clock_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_en,
    input  logic       i_load,
    input  logic [7:0] i_ld_val,
    output logic [7:0] o_q,
    output logic       o_borrow
);

    logic [7:0] r_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_q <= 8'h00;
        end else if (i_load) begin
            r_q <= i_ld_val;
        end else if (i_en) begin
            if (r_q[3:0] == 4'h0) begin
                r_q[3:0] <= UNIT_MAX;
                r_q[7:4] <= (r_q[7:4] == 4'h0) ? TENS_MAX : r_q[7:4] - 4'h1;
            end else begin
                r_q[3:0] <= r_q[3:0] - 4'h1;
            end
        end
    end

    assign o_q      = r_q;
    assign o_borrow = i_en && (r_q == 8'h00);

endmodule

// File: rtl/countdown60x60.sv
// BCD MM:SS countdown timer with IDLE/RUN/PAUSE/EXPIRED control.
// Build option COUNTDOWN_AUTO_RELOAD_EN: reload the last preset on reaching 00:00.
module countdown60x60
    import clock_pkg::*;
(
    input  logic             CP,
    input  logic             CR,
    countdown60x60_if.slave  bus
);

    localparam logic [1:0] S_IDLE    = IDLE;
    localparam logic [1:0] S_RUN     = RUN;
    localparam logic [1:0] S_PAUSE   = PAUSE;
    localparam logic [1:0] S_EXPIRED = EXPIRED;

    logic [1:0]  r_state;
    logic [1:0]  w_next;
    logic        r_busy;
    logic        r_done;
    logic        r_expired;
    logic        r_loaderr;

    logic [7:0]  w_sec;
    logic [7:0]  w_min;
    logic [15:0] w_cnt;
    logic        w_sec_borrow;
    logic        w_unused_min_borrow;
    logic        w_preset_ok;
    logic        w_load_ok;
    logic        w_load_bad;
    logic        w_stop;
    logic        w_start;
    logic        w_dec;
    logic        w_last;
    logic        w_reload;
    logic        w_ld;
    logic [15:0] w_ld_val;

    assign w_cnt       = {w_min, w_sec};
    assign w_preset_ok = preset_ok(bus.Preset);
    assign w_load_ok   = bus.Load && w_preset_ok;
    assign w_load_bad  = bus.Load && !w_preset_ok;

    // Any Load, valid or not, consumes the edge: Stop, Start and EN are dropped.
    assign w_stop  = !bus.Load && bus.Stop && (r_state == S_RUN);
    assign w_start = !bus.Load && bus.Start && (w_cnt != 16'h0000) &&
                     ((r_state == S_IDLE) || (r_state == S_PAUSE));
    assign w_dec   = !bus.Load && !bus.Stop && bus.EN && (r_state == S_RUN);
    assign w_last  = w_dec && (w_cnt == 16'h0001);

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    logic [15:0] r_preset;

    always_ff @(posedge CP) begin
        if (CR) begin
            r_preset <= 16'h0000;
        end else if (w_load_ok) begin
            r_preset <= bus.Preset;
        end
    end

    // An all-zero preset cannot be reloaded meaningfully, so it expires instead.
    assign w_reload = w_last && (r_preset != 16'h0000);
    assign w_ld_val = bus.Load ? bus.Preset : r_preset;
`else
    assign w_reload = 1'b0;
    assign w_ld_val = bus.Preset;
`endif

    assign w_ld = w_load_ok || w_reload;

    down60 u_sec (
        .i_clk    (CP),
        .i_rst    (CR),
        .i_en     (w_dec),
        .i_load   (w_ld),
        .i_ld_val (w_ld_val[7:0]),
        .o_q      (w_sec),
        .o_borrow (w_sec_borrow)
    );

    down60 u_min (
        .i_clk    (CP),
        .i_rst    (CR),
        .i_en     (w_sec_borrow),
        .i_load   (w_ld),
        .i_ld_val (w_ld_val[15:8]),
        .o_q      (w_min),
        .o_borrow (w_unused_min_borrow)
    );

    always_comb begin
        w_next = r_state;
        if (w_load_ok) begin
            w_next = S_IDLE;
        end else if (w_load_bad) begin
            w_next = r_state;
        end else if (w_stop) begin
            w_next = S_PAUSE;
        end else if (w_start) begin
            w_next = S_RUN;
        end else if (w_last) begin
            w_next = w_reload ? S_RUN : S_EXPIRED;
        end
    end

    // Flags are registered from the next state so they move with Cnt.
    always_ff @(posedge CP) begin
        if (CR) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_expired <= 1'b0;
            r_loaderr <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_busy    <= (w_next == S_RUN);
            r_done    <= w_last;
            r_expired <= (w_next == S_EXPIRED);
            r_loaderr <= w_load_bad;
        end
    end

    assign bus.Cnt     = w_cnt;
    assign bus.Busy    = r_busy;
    assign bus.Done    = r_done;
    assign bus.Expired = r_expired;
    assign bus.LoadErr = r_loaderr;

endmodule

// File: tb/tb_countdown60x60.sv
// Directed bench for countdown60x60: one linear stimulus sequence with
// hand-computed expectations checked by immediate assertions.
module tb_countdown60x60;

    logic CP;
    logic CR;
    int   checks;
    int   errors;

    countdown60x60_if bus ();

    countdown60x60 dut (
        .CP  (CP),
        .CR  (CR),
        .bus (bus.slave)
    );

    initial CP = 1'b0;
    always #5 CP = ~CP;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply the currently driven inputs for one edge, then drop all pulses.
    task automatic step();
        @(posedge CP);
        #1;
        CR         = 1'b0;
        bus.EN     = 1'b0;
        bus.Load   = 1'b0;
        bus.Start  = 1'b0;
        bus.Stop   = 1'b0;
    endtask

    task automatic load(input logic [15:0] p);
        bus.Load   = 1'b1;
        bus.Preset = p;
        step();
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        CR         = 1'b1;
        bus.EN     = 1'b0;
        bus.Load   = 1'b0;
        bus.Start  = 1'b0;
        bus.Stop   = 1'b0;
        bus.Preset = 16'h0000;
        step();

        // Activity before reset
        load(16'h1234);
        bus.Start = 1'b1; step();
        for (int i = 0; i < 3; i++) begin
            bus.EN = 1'b1; step();
        end
        chk("pre_reset_cnt", bus.Cnt, 16'h1231);
        CR = 1'b1; step();
        chk("rst_cnt", bus.Cnt, 16'h0000);
        chk("rst_busy", 16'(bus.Busy), 16'h0);
        chk("rst_done", 16'(bus.Done), 16'h0);
        chk("rst_expired", 16'(bus.Expired), 16'h0);
        chk("rst_loaderr", 16'(bus.LoadErr), 16'h0);

        // 01:00 countdown with minute borrow
        load(16'h0100);
        chk("load0100_cnt", bus.Cnt, 16'h0100);
        chk("load0100_busy", 16'(bus.Busy), 16'h0);
        bus.Start = 1'b1; step();
        chk("start_busy", 16'(bus.Busy), 16'h1);
        bus.EN = 1'b1; step();
        chk("dec_0059", bus.Cnt, 16'h0059);
        bus.EN = 1'b1; step();
        chk("dec_0058", bus.Cnt, 16'h0058);
        bus.EN = 1'b1; step();
        chk("dec_0057", bus.Cnt, 16'h0057);
        chk("dec_busy", 16'(bus.Busy), 16'h1);

        // Reaching 00:00
        load(16'h0002);
        bus.Start = 1'b1; step();
        bus.EN = 1'b1; step();
        chk("dec_0001", bus.Cnt, 16'h0001);
        chk("done_early", 16'(bus.Done), 16'h0);
        bus.EN = 1'b1; step();
        chk("done_pulse", 16'(bus.Done), 16'h1);
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        chk("reload_cnt", bus.Cnt, 16'h0002);
        chk("reload_busy", 16'(bus.Busy), 16'h1);
        chk("reload_expired", 16'(bus.Expired), 16'h0);
        step();
        chk("done_one_cycle", 16'(bus.Done), 16'h0);
`else
        chk("zero_cnt", bus.Cnt, 16'h0000);
        chk("expired_set", 16'(bus.Expired), 16'h1);
        chk("expired_busy", 16'(bus.Busy), 16'h0);
        step();
        chk("done_one_cycle", 16'(bus.Done), 16'h0);
        bus.EN = 1'b1; step();
        chk("expired_hold_cnt", bus.Cnt, 16'h0000);
        bus.Start = 1'b1; step();
        chk("expired_start_ign", 16'(bus.Expired), 16'h1);
        chk("expired_start_busy", 16'(bus.Busy), 16'h0);
`endif
        load(16'h0000);
        chk("load_clears_expired", 16'(bus.Expired), 16'h0);

        // Pause / resume across 10:00
        load(16'h1000);
        bus.Start = 1'b1; step();
        bus.EN = 1'b1; step();
        chk("dec_0959", bus.Cnt, 16'h0959);
        bus.Stop = 1'b1; step();
        chk("pause_busy", 16'(bus.Busy), 16'h0);
        for (int i = 0; i < 5; i++) begin
            bus.EN = 1'b1;
            @(posedge CP);
            #1;
        end
        bus.EN = 1'b0;
        chk("pause_hold", bus.Cnt, 16'h0959);
        bus.Start = 1'b1; step();
        bus.EN = 1'b1; step();
        chk("resume_0958", bus.Cnt, 16'h0958);

        // EN held high: one decrement per cycle, including tens borrow
        load(16'h5910);
        bus.Start = 1'b1; step();
        bus.EN = 1'b1;
        @(posedge CP); #1;
        @(posedge CP); #1;
        bus.EN = 1'b0;
        chk("held_en_5908", bus.Cnt, 16'h5908);

        // Invalid presets
        load(16'h1234);
        load(16'h6A00);
        chk("bad_loaderr", 16'(bus.LoadErr), 16'h1);
        chk("bad_cnt", bus.Cnt, 16'h1234);
        step();
        chk("loaderr_one_cycle", 16'(bus.LoadErr), 16'h0);
        load(16'h0060);
        chk("bad_sec_tens", 16'(bus.LoadErr), 16'h1);
        chk("bad_sec_tens_cnt", bus.Cnt, 16'h1234);
        load(16'h5959);
        chk("max_preset", bus.Cnt, 16'h5959);
        chk("max_preset_err", 16'(bus.LoadErr), 16'h0);

        // Start with zero count is ignored
        CR = 1'b1; step();
        bus.Start = 1'b1; step();
        chk("zero_start_busy", 16'(bus.Busy), 16'h0);
        chk("zero_start_done", 16'(bus.Done), 16'h0);
        bus.EN = 1'b1; step();
        chk("zero_start_cnt", bus.Cnt, 16'h0000);

        // Same-cycle events
        load(16'h0005);
        bus.Start = 1'b1; bus.EN = 1'b1; step();
        chk("start_en_cnt", bus.Cnt, 16'h0005);
        chk("start_en_busy", 16'(bus.Busy), 16'h1);
        bus.Stop = 1'b1; bus.EN = 1'b1; step();
        chk("stop_en_cnt", bus.Cnt, 16'h0005);
        chk("stop_en_busy", 16'(bus.Busy), 16'h0);
        load(16'h3100);
        bus.Start = 1'b1; step();
        bus.EN = 1'b1; step();
        chk("dec_3059", bus.Cnt, 16'h3059);
        bus.EN = 1'b1; load(16'h3000);
        chk("load_en_cnt", bus.Cnt, 16'h3000);
        chk("load_en_busy", 16'(bus.Busy), 16'h0);
        bus.EN = 1'b1; step();
        chk("load_en_idle", bus.Cnt, 16'h3000);
        CR = 1'b1; load(16'h4500);
        chk("cr_load_cnt", bus.Cnt, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
